shift_register: RTL and testbench
=================================

Name: shift_register

Overview:
- Parameterised synchronous shift register; default width is 8 bits.
- Operation each clock is selected by a 2-bit mode code: clear, parallel load, logical shift left, logical shift right.
- General-purpose datapath utility. The register value is driven straight out; there is no handshake.

Parameters:
- WIDTH, 8, register and data width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous active-low reset; clears the register.
- mode  input  2  operation select, sampled on each rising clk edge.
- data_in  input  WIDTH  parallel load data, used only when mode = 2'b01.
- out  output  WIDTH  current register contents (registered output).

Behaviour:
- One clock domain (clk); reset is asynchronous and active-low (rst_n).
- Reset: asserting rst_n low forces out to all zeros immediately, with no clock needed.
  - While rst_n is low, out holds zero regardless of mode or data_in.
  - Deassertion takes effect at the next rising clk edge after rst_n goes high.
- Reset mid-operation: abandons any load or shift in progress; no state is retained.
- All mode actions update on the rising clk edge only; out changes only at that edge (or on reset).
- Latency: one cycle from mode/data_in sampling to out.
- Mode decode, where R is the register value before the edge:
  - 2'b00 CLEAR: R becomes 0. This is a synchronous clear, distinct from rst_n.
  - 2'b01 LOAD: R becomes data_in.
  - 2'b10 SHIFT LEFT: R becomes {R[WIDTH-2:0], 1'b0}. MSB is discarded; 0 enters the LSB.
  - 2'b11 SHIFT RIGHT: R becomes {1'b0, R[WIDTH-1:1]}. LSB is discarded; 0 enters the MSB. This is a logical shift; the sign is not preserved.
- There is no hold mode: the register changes, or is cleared, on every clock edge.
- Repeated shifts: WIDTH consecutive shifts in either direction yield all zeros. Further shifts of zero stay zero.
- Boundary values:
  - Shifting left with the MSB at 1 drops that bit silently.
  - Shifting right with the LSB at 1 drops that bit silently.
  - There is no carry or overflow output.
- X/Z on mode: no required behaviour. A case statement with a default of CLEAR is required so that synthesis is fully specified.
- Inputs are assumed synchronous to clk. No internal synchronisers.

Test Plan:
- Reset/clear:
  - rst_n low mid-cycle after loading 8'hFF -> out = 8'h00 immediately, without waiting for a clock.
  - Release rst_n, then mode = 00 for one edge -> out = 8'h00.
- Parallel load:
  - mode = 01, data_in = 8'hAA -> out = 8'hAA after one edge.
  - Changing data_in between edges does not affect out.
- Shift left: starting at 8'hAA, mode = 10 for three edges -> 8'h54, 8'hA8, 8'h50.
- Shift right: continuing from 8'h50, mode = 11 for three edges -> 8'h28, 8'h14, 8'h0A.
  - Then mode = 00 for one edge -> 8'h00.
- Exhaustive shift-out:
  - Load 8'hFF, 8 shifts left -> 8'h00, with the MSB dropping each cycle (8'hFE, 8'hFC, ...).
  - Load 8'h81, 1 shift right -> 8'h40.
- Reset during shifting: assert rst_n mid-sequence -> out = 0 at once.
  - Shifts after release operate on 0 and out stays 8'h00 until a LOAD.

Source files
------------

// File: rtl/shift_register.sv
// Parameterised shift register with a 2-bit mode select: clear, load, shift left, shift right.
// The register value is driven straight out, so out changes only on a clk edge or on reset.
module shift_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] out
);

  localparam logic [1:0] MODE_CLEAR = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_SHL   = 2'b10;
  localparam logic [1:0] MODE_SHR   = 2'b11;

  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] shreg_q;

  // Next-state decode; unknown mode codes fall back to clear so synthesis is fully specified.
  always_comb begin
    shreg_d = {WIDTH{1'b0}};
    case (mode)
      MODE_CLEAR: shreg_d = {WIDTH{1'b0}};
      MODE_LOAD:  shreg_d = data_in;
      MODE_SHL:   shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      MODE_SHR:   shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      default:    shreg_d = {WIDTH{1'b0}};
    endcase
  end

  // Register state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= {WIDTH{1'b0}};
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign out = shreg_q;

endmodule

// File: tb/tb_shift_register.sv
// Scoreboard bench for shift_register: stimulus pushes hand-computed expectations,
// a monitor pops and compares one entry after each rising edge.
module tb_shift_register;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic [7:0] data_in;
  logic [7:0] out;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int checks;
  int errors;

  shift_register #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mode   (mode),
    .data_in(data_in),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Immediate comparison used for the asynchronous (no clock) cases.
  task automatic check_now(input string name, input logic [7:0] exp);
    checks = checks + 1;
    if (out !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: out=%h expected=%h", name, out, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue the value expected after the next rise.
  task automatic step(input logic [1:0] m, input logic [7:0] d, input logic [7:0] exp,
                      input string name);
    sb_entry_t e;
    @(negedge clk);
    mode    = m;
    data_in = d;
    e.exp   = exp;
    e.name  = name;
    sb_q.push_back(e);
  endtask

  // Monitor: the register is presented every cycle, so compare one entry per rising edge.
  initial begin
    sb_entry_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks = checks + 1;
        if (out !== e.exp) begin
          errors = errors + 1;
          $display("FAIL %s: out=%h expected=%h", e.name, out, e.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] shl_exp [8];
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    mode    = 2'b01;
    data_in = 8'hFF;
    #1;
    check_now("reset_init", 8'h00);

    @(negedge clk);
    rst_n = 1'b1;
    step(2'b00, 8'h00, 8'h00, "clear_after_release");

    // Async reset after loading all ones.
    step(2'b01, 8'hFF, 8'hFF, "load_ff");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_rst_after_ff", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b00, 8'h00, 8'h00, "clear_after_rst");

    step(2'b01, 8'hAA, 8'hAA, "load_aa");
    @(posedge clk);
    #2;
    data_in = 8'h55;
    #1;
    check_now("data_in_change_ignored", 8'hAA);

    step(2'b10, 8'h55, 8'h54, "shl_1");
    step(2'b10, 8'h00, 8'hA8, "shl_2");
    step(2'b10, 8'h00, 8'h50, "shl_3");
    step(2'b11, 8'h00, 8'h28, "shr_1");
    step(2'b11, 8'h00, 8'h14, "shr_2");
    step(2'b11, 8'h00, 8'h0A, "shr_3");
    step(2'b00, 8'hC3, 8'h00, "sync_clear");

    // All ones shifted out to the left, MSB dropping each cycle.
    shl_exp[0] = 8'hFE; shl_exp[1] = 8'hFC; shl_exp[2] = 8'hF8; shl_exp[3] = 8'hF0;
    shl_exp[4] = 8'hE0; shl_exp[5] = 8'hC0; shl_exp[6] = 8'h80; shl_exp[7] = 8'h00;
    step(2'b01, 8'hFF, 8'hFF, "load_ff_shiftout");
    for (int i = 0; i < 8; i++) begin
      step(2'b10, 8'h00, shl_exp[i], $sformatf("shiftout_%0d", i));
    end
    step(2'b10, 8'h00, 8'h00, "shl_zero_stays");

    step(2'b01, 8'h81, 8'h81, "load_81");
    step(2'b11, 8'h00, 8'h40, "shr_lsb_drop");

    // Reset in the middle of a shift sequence.
    step(2'b01, 8'hFF, 8'hFF, "load_ff_2");
    step(2'b11, 8'h00, 8'h7F, "shr_7f");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_rst_mid_shift", 8'h00);
    step(2'b10, 8'hFF, 8'h00, "shl_held_in_reset");
    step(2'b01, 8'hAA, 8'h00, "load_held_in_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    mode  = 2'b10;
    step(2'b10, 8'h00, 8'h00, "shl_after_release");
    step(2'b11, 8'h00, 8'h00, "shr_after_release");
    step(2'b01, 8'h3C, 8'h3C, "load_after_release");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10; i++) begin
      if (sb_q.size() > 0) begin
        @(posedge clk);
        #2;
      end
    end
    if (sb_q.size() > 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain: pending=%0d expected=0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
